decoder: RTL and testbench

- Instruction decoder of the Jac1-8 8-bit CPU. Sits between the program memory and the datapath.
- Splits a 16-bit instruction into opcode, register selects and an 8-bit literal.
- Drives the register-file read/write controls, the ALU/decoder write-mux select, the status-register write control and the program-counter load controls.
- Decode is combinational; reset only gates the side-effecting enables.

---
 rtl/jac_pkg.sv | 51 +++++
 rtl/decoder_if.sv | 44 ++++
 rtl/branch_cond.sv | 30 +++
 rtl/decoder.sv | 131 +++++++++++++
 tb/tb_decoder.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/jac_pkg.sv
// +--------------------------------------------------------------------------+
// | jac_pkg : shared widths, opcodes and field positions for the Jac1-8 core |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package jac_pkg;

  localparam int DataWidth         = 8;
  localparam int SEL_WIDTH         = 2;
  localparam int PROGRAM_DataWidth = 16;
  localparam int NumOpCodeBits     = 5;
  localparam int ParamBits         = 8;
  localparam int NumStatusBits     = 3;
  localparam int OP1_BIT_POS       = 9;
  localparam int OP2_BIT_POS       = 4;

  localparam logic [NumOpCodeBits-1:0] OP_NOP   = 5'h00;
  localparam logic [NumOpCodeBits-1:0] OP_ADD   = 5'h01;
  localparam logic [NumOpCodeBits-1:0] OP_SUB   = 5'h02;
  localparam logic [NumOpCodeBits-1:0] OP_AND   = 5'h03;
  localparam logic [NumOpCodeBits-1:0] OP_OR    = 5'h04;
  localparam logic [NumOpCodeBits-1:0] OP_NOT   = 5'h05;
  localparam logic [NumOpCodeBits-1:0] OP_XOR   = 5'h06;
  localparam logic [NumOpCodeBits-1:0] OP_SHL   = 5'h07;
  localparam logic [NumOpCodeBits-1:0] OP_SHR   = 5'h08;
  localparam logic [NumOpCodeBits-1:0] OP_VAL   = 5'h09;
  localparam logic [NumOpCodeBits-1:0] OP_GOTO  = 5'h10;
  localparam logic [NumOpCodeBits-1:0] OP_IFZ   = 5'h11;
  localparam logic [NumOpCodeBits-1:0] OP_IFNZ  = 5'h12;
  localparam logic [NumOpCodeBits-1:0] OP_IFEQ  = 5'h13;
  localparam logic [NumOpCodeBits-1:0] OP_IFST  = 5'h14;
  localparam logic [NumOpCodeBits-1:0] OP_IFGT  = 5'h15;
  localparam logic [NumOpCodeBits-1:0] OP_RES16 = 5'h16;

  localparam logic SEL_ALU     = 1'b1;
  localparam logic SEL_DECODER = 1'b0;

  localparam int STAT_Z  = 2;
  localparam int STAT_GT = 1;
  localparam int STAT_ST = 0;

  // Two-operand ALU ops: both register ports read, result back into op1.
  function automatic logic is_binary_alu_op(input logic [NumOpCodeBits-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_if.sv
// +--------------------------------------------------------------------------+
// | decoder_if : instruction/status in, datapath controls out                |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

interface decoder_if;
  import jac_pkg::*;

  logic [PROGRAM_DataWidth-1:0] instruction;
  logic [NumStatusBits-1:0]     status;
  logic [NumOpCodeBits-1:0]     opcode;
  logic [ParamBits-1:0]         param;
  logic [DataWidth-1:0]         literal_adr;
  logic [SEL_WIDTH-1:0]         rd_sel1;
  logic [SEL_WIDTH-1:0]         rd_sel2;
  logic                         rd_en1;
  logic                         rd_en2;
  logic                         wr_en;
  logic [SEL_WIDTH-1:0]         wr_sel;
  logic                         sel_reg_in_alu_decoder;
  logic                         add_offset;
  logic                         cnt_wr_en;
  logic                         stat_wr_en;
  logic                         stat_reg_in_alu_decoder;
  logic [NumStatusBits-1:0]     status_out;

  modport master (
    output instruction, status,
    input  opcode, param, literal_adr, rd_sel1, rd_sel2, rd_en1, rd_en2,
           wr_en, wr_sel, sel_reg_in_alu_decoder, add_offset, cnt_wr_en,
           stat_wr_en, stat_reg_in_alu_decoder, status_out
  );

  modport slave (
    input  instruction, status,
    output opcode, param, literal_adr, rd_sel1, rd_sel2, rd_en1, rd_en2,
           wr_en, wr_sel, sel_reg_in_alu_decoder, add_offset, cnt_wr_en,
           stat_wr_en, stat_reg_in_alu_decoder, status_out
  );

endinterface

`default_nettype wire

// File: rtl/branch_cond.sv
// +--------------------------------------------------------------------------+
// | branch_cond : evaluates conditional-branch opcodes against status flags  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module branch_cond
  import jac_pkg::*;
(
  input  wire logic [NumOpCodeBits-1:0] opcode,
  input  wire logic [NumStatusBits-1:0] status,
  output logic                          take
);

  // IFEQ relies on the preceding compare having set Z, so it shares IFZ's test.
  always_comb begin
    take = 1'b0;
    case (opcode)
      OP_IFZ,
      OP_IFEQ: take = status[STAT_Z];
      OP_IFNZ: take = ~status[STAT_Z];
      OP_IFST: take = status[STAT_ST];
      OP_IFGT: take = status[STAT_GT];
      default: take = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/decoder.sv
// +--------------------------------------------------------------------------+
// | decoder : combinational Jac1-8 instruction decoder                       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module decoder
  import jac_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst,
  decoder_if.slave  bus
);

  logic [NumOpCodeBits-1:0] opcode;
  logic [SEL_WIDTH-1:0]     op1;
  logic [SEL_WIDTH-1:0]     op2;
  logic                     take;

  logic [SEL_WIDTH-1:0]     rd_sel1_d;
  logic [SEL_WIDTH-1:0]     rd_sel2_d;
  logic                     rd_en1_d;
  logic                     rd_en2_d;
  logic                     wr_en_d;
  logic [SEL_WIDTH-1:0]     wr_sel_d;
  logic                     sel_d;
  logic                     add_offset_d;
  logic                     cnt_wr_en_d;
  logic                     stat_wr_en_d;
  logic                     wr_en_g;

  // Nothing here is clocked and bit 10 of the instruction carries no field.
  logic unused_bits;
  assign unused_bits = clk ^ bus.instruction[10];

  assign opcode = bus.instruction[PROGRAM_DataWidth-1 -: NumOpCodeBits];
  assign op1    = bus.instruction[OP1_BIT_POS -: SEL_WIDTH];
  assign op2    = bus.instruction[OP2_BIT_POS -: SEL_WIDTH];

  branch_cond u_branch_cond (
    .opcode (opcode),
    .status (bus.status),
    .take   (take)
  );

  always_comb begin
    rd_sel1_d    = '0;
    rd_sel2_d    = '0;
    rd_en1_d     = 1'b0;
    rd_en2_d     = 1'b0;
    wr_en_d      = 1'b0;
    wr_sel_d     = '0;
    sel_d        = SEL_DECODER;
    add_offset_d = 1'b0;
    cnt_wr_en_d  = 1'b0;
    stat_wr_en_d = 1'b0;

    if (is_binary_alu_op(opcode)) begin
      rd_sel1_d    = op1;
      rd_sel2_d    = op2;
      rd_en1_d     = 1'b1;
      rd_en2_d     = 1'b1;
      wr_en_d      = 1'b1;
      wr_sel_d     = op1;
      sel_d        = SEL_ALU;
      stat_wr_en_d = 1'b1;
    end else begin
      case (opcode)
        OP_NOT: begin
          rd_sel2_d    = op2;
          rd_en2_d     = 1'b1;
          wr_en_d      = 1'b1;
          wr_sel_d     = op1;
          sel_d        = SEL_ALU;
          stat_wr_en_d = 1'b1;
        end
        // Shift amount travels on param, so the second read port stays idle.
        OP_SHL,
        OP_SHR: begin
          rd_sel1_d    = op1;
          rd_en1_d     = 1'b1;
          wr_en_d      = 1'b1;
          wr_sel_d     = op1;
          sel_d        = SEL_ALU;
          stat_wr_en_d = 1'b1;
        end
        OP_VAL: begin
          wr_en_d  = 1'b1;
          wr_sel_d = op1;
          sel_d    = SEL_DECODER;
        end
        OP_GOTO: begin
          cnt_wr_en_d = 1'b1;
        end
        OP_IFZ,
        OP_IFNZ,
        OP_IFEQ,
        OP_IFST,
        OP_IFGT: begin
          cnt_wr_en_d  = take;
          add_offset_d = take;
        end
        default: begin
          cnt_wr_en_d = 1'b0;
        end
      endcase
    end
  end

  // Reset masks only the enables that change architectural state.
  assign wr_en_g = wr_en_d & ~rst;

  assign bus.opcode                  = opcode;
  assign bus.param                   = bus.instruction[ParamBits-1:0];
  assign bus.literal_adr             = bus.instruction[DataWidth-1:0];
  assign bus.rd_sel1                 = rd_sel1_d;
  assign bus.rd_sel2                 = rd_sel2_d;
  assign bus.rd_en1                  = rd_en1_d;
  assign bus.rd_en2                  = rd_en2_d;
  assign bus.wr_en                   = wr_en_g;
  assign bus.wr_sel                  = wr_en_g ? wr_sel_d : '0;
  assign bus.sel_reg_in_alu_decoder  = sel_d;
  assign bus.add_offset              = add_offset_d & ~rst;
  assign bus.cnt_wr_en               = cnt_wr_en_d & ~rst;
  assign bus.stat_wr_en              = stat_wr_en_d & ~rst;
  assign bus.stat_reg_in_alu_decoder = SEL_ALU;
  assign bus.status_out              = '0;

endmodule

`default_nettype wire

// File: tb/tb_decoder.sv
// +--------------------------------------------------------------------------+
// | tb_decoder : directed-vector scoreboard bench for the Jac1-8 decoder     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_decoder;
  import jac_pkg::*;

  typedef struct packed {
    logic [4:0] opcode;
    logic [7:0] param;
    logic [7:0] literal_adr;
    logic [1:0] rd_sel1;
    logic [1:0] rd_sel2;
    logic       rd_en1;
    logic       rd_en2;
    logic       wr_en;
    logic [1:0] wr_sel;
    logic       sel_alu;
    logic       add_offset;
    logic       cnt_wr_en;
    logic       stat_wr_en;
    logic       stat_src;
    logic [2:0] status_out;
  } out_t;

  logic clk;
  logic rst;

  decoder_if bus ();

  decoder u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  out_t  exp_q  [$];
  out_t  mask_q [$];
  string name_q [$];
  int    n_vec  = 0;
  int    n_miss = 0;

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [1:0] op1,
                                     input logic [7:0] lit);
    return {op, 1'b0, op1, lit};
  endfunction

  // Raw fields plus the all-defaults control word.
  function automatic out_t base(input logic [15:0] ins);
    out_t e;
    e             = '0;
    e.opcode      = ins[15:11];
    e.param       = ins[7:0];
    e.literal_adr = ins[7:0];
    e.stat_src    = 1'b1;
    return e;
  endfunction

  task automatic apply(input string nm, input logic [15:0] ins, input logic [2:0] st,
                       input logic r, input out_t e, input logic chk_wr_sel);
    out_t m;
    @(posedge clk);
    #1;
    bus.instruction = ins;
    bus.status      = st;
    rst             = r;
    m = '1;
    if (!chk_wr_sel) m.wr_sel = 2'b00;
    exp_q.push_back(e);
    mask_q.push_back(m);
    name_q.push_back(nm);
  endtask

  // Monitor: the decoder answers within the same cycle, so each negedge
  // retires whatever vector was driven just after the preceding posedge.
  initial begin
    out_t  act;
    out_t  e;
    out_t  m;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        m  = mask_q.pop_front();
        nm = name_q.pop_front();
        act.opcode      = bus.opcode;
        act.param       = bus.param;
        act.literal_adr = bus.literal_adr;
        act.rd_sel1     = bus.rd_sel1;
        act.rd_sel2     = bus.rd_sel2;
        act.rd_en1      = bus.rd_en1;
        act.rd_en2      = bus.rd_en2;
        act.wr_en       = bus.wr_en;
        act.wr_sel      = bus.wr_sel;
        act.sel_alu     = bus.sel_reg_in_alu_decoder;
        act.add_offset  = bus.add_offset;
        act.cnt_wr_en   = bus.cnt_wr_en;
        act.stat_wr_en  = bus.stat_wr_en;
        act.stat_src    = bus.stat_reg_in_alu_decoder;
        act.status_out  = bus.status_out;
        n_vec++;
        if ((act & m) !== (e & m)) begin
          n_miss++;
          $display("FAIL %s: got %h required %h (mask %h)", nm, act, e, m);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    out_t        e;
    logic [15:0] ins;
    logic [2:0]  sv;

    rst             = 1'b0;
    bus.instruction = '0;
    bus.status      = '0;
    repeat (2) @(posedge clk);

    apply("nop_idle", 16'h0000, 3'b000, 1'b0, base(16'h0000), 1'b1);

    ins = mk(OP_ADD, 2'b01, 8'h10);
    e = base(ins); e.rd_sel1 = 2'b01; e.rd_sel2 = 2'b10; e.rd_en1 = 1; e.rd_en2 = 1;
    e.wr_en = 1; e.wr_sel = 2'b01; e.sel_alu = 1; e.stat_wr_en = 1;
    apply("add", ins, 3'b000, 1'b0, e, 1'b1);

    ins = mk(OP_SUB, 2'b11, 8'h08);
    e = base(ins); e.rd_sel1 = 2'b11; e.rd_sel2 = 2'b01; e.rd_en1 = 1; e.rd_en2 = 1;
    e.wr_en = 1; e.wr_sel = 2'b11; e.sel_alu = 1; e.stat_wr_en = 1;
    apply("sub", ins, 3'b111, 1'b0, e, 1'b1);

    // Bit 10 set must not disturb anything.
    ins = mk(OP_XOR, 2'b00, 8'h18) | 16'h0400;
    e = base(ins); e.rd_sel1 = 2'b00; e.rd_sel2 = 2'b11; e.rd_en1 = 1; e.rd_en2 = 1;
    e.wr_en = 1; e.wr_sel = 2'b00; e.sel_alu = 1; e.stat_wr_en = 1;
    apply("xor_bit10", ins, 3'b000, 1'b0, e, 1'b1);

    ins = mk(OP_OR, 2'b10, 8'h0F);
    e = base(ins); e.rd_sel1 = 2'b10; e.rd_sel2 = 2'b01; e.rd_en1 = 1; e.rd_en2 = 1;
    e.wr_en = 1; e.wr_sel = 2'b10; e.sel_alu = 1; e.stat_wr_en = 1;
    apply("or", ins, 3'b000, 1'b0, e, 1'b1);

    ins = mk(OP_NOT, 2'b10, 8'h47);
    e = base(ins); e.rd_en2 = 1; e.rd_sel2 = 2'b00;
    e.wr_en = 1; e.wr_sel = 2'b10; e.sel_alu = 1; e.stat_wr_en = 1;
    apply("not", ins, 3'b000, 1'b0, e, 1'b1);

    ins = mk(OP_NOT, 2'b01, 8'h18);
    e = base(ins); e.rd_en2 = 1; e.rd_sel2 = 2'b11;
    e.wr_en = 1; e.wr_sel = 2'b01; e.sel_alu = 1; e.stat_wr_en = 1;
    apply("not_op2", ins, 3'b000, 1'b0, e, 1'b1);

    ins = mk(OP_VAL, 2'b11, 8'hA5);
    e = base(ins); e.wr_en = 1; e.wr_sel = 2'b11;
    apply("val", ins, 3'b000, 1'b0, e, 1'b1);

    ins = mk(OP_SHR, 2'b10, 8'h02);
    e = base(ins); e.rd_en1 = 1; e.rd_sel1 = 2'b10;
    e.wr_en = 1; e.wr_sel = 2'b10; e.sel_alu = 1; e.stat_wr_en = 1;
    apply("shr", ins, 3'b000, 1'b0, e, 1'b1);

    ins = mk(OP_SHL, 2'b01, 8'h1B);
    e = base(ins); e.rd_en1 = 1; e.rd_sel1 = 2'b01;
    e.wr_en = 1; e.wr_sel = 2'b01; e.sel_alu = 1; e.stat_wr_en = 1;
    apply("shl", ins, 3'b000, 1'b0, e, 1'b1);

    ins = mk(OP_GOTO, 2'b11, 8'h3F);
    e = base(ins); e.cnt_wr_en = 1;
    apply("goto", ins, 3'b111, 1'b0, e, 1'b1);

    ins = mk(OP_IFZ, 2'b00, 8'h08);
    apply("ifz_not_taken", ins, 3'b000, 1'b0, base(ins), 1'b1);

    ins = mk(OP_IFZ, 2'b00, 8'h09);
    e = base(ins); e.cnt_wr_en = 1; e.add_offset = 1;
    apply("ifz_taken", ins, 3'b100, 1'b0, e, 1'b1);

    ins = mk(OP_IFEQ, 2'b01, 8'hF0);
    e = base(ins); e.cnt_wr_en = 1; e.add_offset = 1;
    apply("ifeq_taken", ins, 3'b100, 1'b0, e, 1'b1);

    ins = mk(OP_IFEQ, 2'b01, 8'hF0);
    apply("ifeq_not_taken", ins, 3'b011, 1'b0, base(ins), 1'b1);

    for (int s = 0; s < 8; s++) begin
      sv  = s[2:0];
      ins = mk(OP_IFNZ, 2'b00, 8'h21);
      e = base(ins); e.cnt_wr_en = ~sv[2]; e.add_offset = ~sv[2];
      apply("ifnz_sweep", ins, sv, 1'b0, e, 1'b1);
      ins = mk(OP_IFST, 2'b10, 8'h42);
      e = base(ins); e.cnt_wr_en = sv[0]; e.add_offset = sv[0];
      apply("ifst_sweep", ins, sv, 1'b0, e, 1'b1);
      ins = mk(OP_IFGT, 2'b11, 8'h84);
      e = base(ins); e.cnt_wr_en = sv[1]; e.add_offset = sv[1];
      apply("ifgt_sweep", ins, sv, 1'b0, e, 1'b1);
    end

    ins = mk(5'h0A, 2'b11, 8'hFF);
    apply("reserved_0a", ins, 3'b111, 1'b0, base(ins), 1'b1);
    ins = mk(5'h1F, 2'b11, 8'hFF);
    apply("reserved_1f", ins, 3'b111, 1'b0, base(ins), 1'b1);
    ins = mk(OP_RES16, 2'b01, 8'h18);
    apply("reserved_16", ins, 3'b100, 1'b0, base(ins), 1'b1);

    // Reset during a live instruction: enables drop, reads keep decoding.
    ins = mk(OP_AND, 2'b10, 8'h08);
    e = base(ins); e.rd_sel1 = 2'b10; e.rd_sel2 = 2'b01; e.rd_en1 = 1; e.rd_en2 = 1;
    e.wr_en = 1; e.wr_sel = 2'b10; e.sel_alu = 1; e.stat_wr_en = 1;
    apply("and_pre_rst", ins, 3'b000, 1'b0, e, 1'b1);
    e.wr_en = 0; e.stat_wr_en = 0;
    apply("and_in_rst", ins, 3'b000, 1'b1, e, 1'b0);
    e.wr_en = 1; e.stat_wr_en = 1;
    apply("and_post_rst", ins, 3'b000, 1'b0, e, 1'b1);

    ins = mk(OP_GOTO, 2'b00, 8'h3F);
    apply("goto_in_rst", ins, 3'b000, 1'b1, base(ins), 1'b0);

    ins = mk(OP_IFZ, 2'b00, 8'h09);
    apply("ifz_in_rst", ins, 3'b100, 1'b1, base(ins), 1'b0);
    e = base(ins); e.cnt_wr_en = 1; e.add_offset = 1;
    apply("ifz_post_rst", ins, 3'b100, 1'b0, e, 1'b1);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d vectors left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
